// File: rtl/conv_pkg.sv
// Shared constants, state encoding and output bundle for the conv_seq address sequencer.
// Pooling states exist only when CONV_SEQ_POOL_EN is defined.
package conv_pkg;

   localparam int unsigned IMG_W      = 64;
   localparam int unsigned POOL_W     = 32;
   localparam int unsigned TAP_N      = 9;
   localparam int unsigned ADDR_W     = 12;
   localparam int unsigned POS_W      = 6;
   localparam int unsigned POOL_POS_W = 5;
   localparam int unsigned TAP_W      = 4;
   localparam int unsigned CSEL_W     = 3;

   localparam logic [CSEL_W-1:0] CSEL_L0 = 3'b001;
   localparam logic [CSEL_W-1:0] CSEL_L1 = 3'b011;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CONV_RD  = 3'd1,
      CONV_DRN = 3'd2,
      CONV_WR  = 3'd3,
`ifdef CONV_SEQ_POOL_EN
      POOL_RD  = 3'd4,
      POOL_DRN = 3'd5,
      POOL_WR  = 3'd6,
`endif
      DONE     = 3'd7
   } state_t;

   typedef struct packed {
      logic              busy;
      logic [ADDR_W-1:0] iaddr;
      logic              pad;
      logic [TAP_W-1:0]  tap;
      logic              mac_clr;
      logic              mac_en;
      logic              max_clr;
      logic              max_en;
      logic              crd;
      logic [ADDR_W-1:0] caddr_rd;
      logic              cwr;
      logic [ADDR_W-1:0] caddr_wr;
      logic [CSEL_W-1:0] csel;
      logic [POS_W-1:0]  pos_row;
      logic [POS_W-1:0]  pos_col;
   } seq_out_t;

   // 2x2 pooling window read address: (2r+k[1])*64 + (2c+k[0])
   function automatic logic [ADDR_W-1:0] pool_rd_addr(input logic [POOL_POS_W-1:0] r,
                                                      input logic [POOL_POS_W-1:0] c,
                                                      input logic [1:0]            k);
      return {r, k[1], c, k[0]};
   endfunction

endpackage

// File: rtl/conv_win_addr.sv
// 3x3 window tap address generator: (row, col, tap) -> image address and out-of-bounds flag.
module conv_win_addr
   import conv_pkg::*;
(
   input  logic [POS_W-1:0]  row,
   input  logic [POS_W-1:0]  col,
   input  logic [TAP_W-1:0]  tap,
   output logic [ADDR_W-1:0] iaddr,
   output logic              pad
);

   localparam int unsigned EXT_W = POS_W + 1;

   logic [1:0]       dr;
   logic [1:0]       dc;
   logic [EXT_W-1:0] r_ext;
   logic [EXT_W-1:0] c_ext;

   // Offsets held as 0..2 (bias of +1); the extra MSB flags both -1 and IMG_W
   always_comb begin
      dr = 2'd1;
      dc = 2'd1;
      case (tap)
         4'd0: begin dr = 2'd0; dc = 2'd0; end
         4'd1: begin dr = 2'd0; dc = 2'd1; end
         4'd2: begin dr = 2'd0; dc = 2'd2; end
         4'd3: begin dr = 2'd1; dc = 2'd0; end
         4'd4: begin dr = 2'd1; dc = 2'd1; end
         4'd5: begin dr = 2'd1; dc = 2'd2; end
         4'd6: begin dr = 2'd2; dc = 2'd0; end
         4'd7: begin dr = 2'd2; dc = 2'd1; end
         4'd8: begin dr = 2'd2; dc = 2'd2; end
         default: begin dr = 2'd1; dc = 2'd1; end
      endcase
      r_ext = {1'b0, row} + EXT_W'(dr) - EXT_W'(1);
      c_ext = {1'b0, col} + EXT_W'(dc) - EXT_W'(1);
      pad   = r_ext[POS_W] | c_ext[POS_W];
      iaddr = pad ? '0 : {r_ext[POS_W-1:0], c_ext[POS_W-1:0]};
   end

endmodule

// File: rtl/conv_seq.sv
// Convolution / 2x2 max-pool address and strobe sequencer over a 64x64 image.
// Optional pooling pass compiled in with CONV_SEQ_POOL_EN.
module conv_seq
   import conv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ready,
   output logic              busy,
   output logic [ADDR_W-1:0] iaddr,
   output logic              pad,
   output logic [TAP_W-1:0]  tap,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              max_clr,
   output logic              max_en,
   output logic              crd,
   output logic [ADDR_W-1:0] caddr_rd,
   output logic              cwr,
   output logic [ADDR_W-1:0] caddr_wr,
   output logic [CSEL_W-1:0] csel,
   output logic [POS_W-1:0]  pos_row,
   output logic [POS_W-1:0]  pos_col
);

   state_t            state_q;
   state_t            state_d;
   logic [TAP_W-1:0]  tap_q;
   logic [TAP_W-1:0]  tap_d;
   logic [POS_W-1:0]  row_q;
   logic [POS_W-1:0]  row_d;
   logic [POS_W-1:0]  col_q;
   logic [POS_W-1:0]  col_d;
   seq_out_t          out_q;
   seq_out_t          out_d;
   logic [ADDR_W-1:0] win_iaddr_c;
   logic              win_pad_c;

   // Window address is evaluated on the next position so iaddr/pad register with their tap
   conv_win_addr u_win (
      .row   (row_d),
      .col   (col_d),
      .tap   (tap_d),
      .iaddr (win_iaddr_c),
      .pad   (win_pad_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tap_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         row_q   <= row_d;
         col_q   <= col_d;
         out_q   <= out_d;
      end
   end

   // Next state and position
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE: begin
            if (ready) begin
               state_d = CONV_RD;
               tap_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         CONV_RD: begin
            if (tap_q == TAP_W'(TAP_N - 1)) begin
               state_d = CONV_DRN;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + TAP_W'(1);
            end
         end
         CONV_DRN: state_d = CONV_WR;
         CONV_WR: begin
            state_d = CONV_RD;
            if (col_q == POS_W'(IMG_W - 1)) begin
               col_d = '0;
               if (row_q == POS_W'(IMG_W - 1)) begin
                  row_d = '0;
`ifdef CONV_SEQ_POOL_EN
                  state_d = POOL_RD;
`else
                  state_d = DONE;
`endif
               end else begin
                  row_d = row_q + POS_W'(1);
               end
            end else begin
               col_d = col_q + POS_W'(1);
            end
         end
`ifdef CONV_SEQ_POOL_EN
         POOL_RD: begin
            if (tap_q == TAP_W'(3)) begin
               state_d = POOL_DRN;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + TAP_W'(1);
            end
         end
         POOL_DRN: state_d = POOL_WR;
         POOL_WR: begin
            state_d = POOL_RD;
            if (col_q == POS_W'(POOL_W - 1)) begin
               col_d = '0;
               if (row_q == POS_W'(POOL_W - 1)) begin
                  row_d   = '0;
                  state_d = DONE;
               end else begin
                  row_d = row_q + POS_W'(1);
               end
            end else begin
               col_d = col_q + POS_W'(1);
            end
         end
`endif
         DONE: begin
            state_d = IDLE;
            tap_d   = '0;
            row_d   = '0;
            col_d   = '0;
         end
         default: begin
            state_d = IDLE;
            tap_d   = '0;
            row_d   = '0;
            col_d   = '0;
         end
      endcase
   end

   // Output values for the coming cycle; accumulate strobes trail the issuing read by one cycle
   always_comb begin
      out_d         = '0;
      out_d.busy    = (state_d != IDLE) && (state_d != DONE);
      out_d.pos_row = row_d;
      out_d.pos_col = col_d;
      out_d.mac_en  = (state_q == CONV_RD);
      out_d.mac_clr = (state_q == CONV_RD) && (tap_q == '0);
`ifdef CONV_SEQ_POOL_EN
      out_d.max_en  = (state_q == POOL_RD);
      out_d.max_clr = (state_q == POOL_RD) && (tap_q == '0);
`endif
      case (state_d)
         CONV_RD: begin
            out_d.tap   = tap_d;
            out_d.iaddr = win_iaddr_c;
            out_d.pad   = win_pad_c;
         end
         CONV_WR: begin
            out_d.cwr      = 1'b1;
            out_d.csel     = CSEL_L0;
            out_d.caddr_wr = ADDR_W'({row_d, col_d});
         end
`ifdef CONV_SEQ_POOL_EN
         POOL_RD: begin
            out_d.crd      = 1'b1;
            out_d.csel     = CSEL_L0;
            out_d.caddr_rd = pool_rd_addr(row_d[POOL_POS_W-1:0], col_d[POOL_POS_W-1:0], tap_d[1:0]);
         end
         POOL_WR: begin
            out_d.cwr      = 1'b1;
            out_d.csel     = CSEL_L1;
            out_d.caddr_wr = ADDR_W'(row_d) * ADDR_W'(POOL_W) + ADDR_W'(col_d);
         end
`endif
         default: ;
      endcase
   end

   assign busy     = out_q.busy;
   assign iaddr    = out_q.iaddr;
   assign pad      = out_q.pad;
   assign tap      = out_q.tap;
   assign mac_clr  = out_q.mac_clr;
   assign mac_en   = out_q.mac_en;
   assign max_clr  = out_q.max_clr;
   assign max_en   = out_q.max_en;
   assign crd      = out_q.crd;
   assign caddr_rd = out_q.caddr_rd;
   assign cwr      = out_q.cwr;
   assign caddr_wr = out_q.caddr_wr;
   assign csel     = out_q.csel;
   assign pos_row  = out_q.pos_row;
   assign pos_col  = out_q.pos_col;

endmodule

// File: tb/tb_conv_seq.sv
// Self-checking bench for conv_seq: cycle-indexed reference sweep, spot-check table,
// write scoreboard, mid-run reset and restart. Honours CONV_SEQ_POOL_EN.
`timescale 1ns/1ps
module tb_conv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready;
   logic        busy;
   logic [11:0] iaddr;
   logic        pad;
   logic [3:0]  tap;
   logic        mac_clr, mac_en, max_clr, max_en, crd, cwr;
   logic [11:0] caddr_rd, caddr_wr;
   logic [2:0]  csel;
   logic [5:0]  pos_row, pos_col;

   conv_seq dut (
      .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .pad(pad),
      .tap(tap), .mac_clr(mac_clr), .mac_en(mac_en), .max_clr(max_clr), .max_en(max_en),
      .crd(crd), .caddr_rd(caddr_rd), .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel),
      .pos_row(pos_row), .pos_col(pos_col)
   );

   always #5 clk = ~clk;

   localparam int CONV_CYC = 4096 * 11;
`ifdef CONV_SEQ_POOL_EN
   localparam int RUN_CYC  = CONV_CYC + 1024 * 6;
   localparam int POOL_ON  = 1;
`else
   localparam int RUN_CYC  = CONV_CYC;
   localparam int POOL_ON  = 0;
`endif

   typedef struct packed {
      logic        busy;
      logic [11:0] iaddr;
      logic        pad;
      logic [3:0]  tap;
      logic        mac_clr;
      logic        mac_en;
      logic        max_clr;
      logic        max_en;
      logic        crd;
      logic [11:0] caddr_rd;
      logic        cwr;
      logic [11:0] caddr_wr;
      logic [2:0]  csel;
      logic [5:0]  pos_row;
      logic [5:0]  pos_col;
   } outv_t;

   typedef enum int {F_BUSY, F_IADDR, F_PAD, F_TAP, F_MCLR, F_MEN, F_CRD, F_CADDR_RD,
                     F_CWR, F_CADDR_WR, F_CSEL, F_ROW, F_COL} fld_t;

   typedef struct {
      int    n;
      fld_t  f;
      int    v;
      string name;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   outv_t       obs [RUN_CYC + 2];
   vec_t        vecs [$];
   logic [14:0] wr_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic outv_t sample();
      outv_t o;
      o = '{busy, iaddr, pad, tap, mac_clr, mac_en, max_clr, max_en, crd, caddr_rd,
            cwr, caddr_wr, csel, pos_row, pos_col};
      return o;
   endfunction

   // Expected outputs n cycles after the edge that accepted ready
   function automatic outv_t model(int n);
      outv_t e;
      int p, s, r, c, rr, cc;
      e = '0;
      if (n < CONV_CYC) begin
         p = n / 11; s = n % 11; r = p / 64; c = p % 64;
         e.busy = 1'b1; e.pos_row = 6'(r); e.pos_col = 6'(c);
         if (s < 9) begin
            e.tap = 4'(s);
            rr = r + s / 3 - 1;
            cc = c + s % 3 - 1;
            if (rr < 0 || rr > 63 || cc < 0 || cc > 63) e.pad = 1'b1;
            else e.iaddr = 12'(rr * 64 + cc);
         end
         e.mac_en  = (s >= 1 && s <= 9);
         e.mac_clr = (s == 1);
         if (s == 10) begin
            e.cwr = 1'b1; e.csel = 3'b001; e.caddr_wr = 12'(r * 64 + c);
         end
      end else if (n < RUN_CYC) begin
         p = (n - CONV_CYC) / 6; s = (n - CONV_CYC) % 6; r = p / 32; c = p % 32;
         e.busy = 1'b1; e.pos_row = 6'(r); e.pos_col = 6'(c);
         if (s < 4) begin
            e.crd = 1'b1; e.csel = 3'b001;
            e.caddr_rd = 12'((2 * r + s / 2) * 64 + 2 * c + s % 2);
         end
         e.max_en  = (s >= 1 && s <= 4);
         e.max_clr = (s == 1);
         if (s == 5) begin
            e.cwr = 1'b1; e.csel = 3'b011; e.caddr_wr = 12'(r * 32 + c);
         end
      end
      return e;
   endfunction

   function automatic int get(outv_t o, fld_t f);
      case (f)
         F_BUSY:     return int'(o.busy);
         F_IADDR:    return int'(o.iaddr);
         F_PAD:      return int'(o.pad);
         F_TAP:      return int'(o.tap);
         F_MCLR:     return int'(o.mac_clr);
         F_MEN:      return int'(o.mac_en);
         F_CRD:      return int'(o.crd);
         F_CADDR_RD: return int'(o.caddr_rd);
         F_CWR:      return int'(o.cwr);
         F_CADDR_WR: return int'(o.caddr_wr);
         F_CSEL:     return int'(o.csel);
         F_ROW:      return int'(o.pos_row);
         default:    return int'(o.pos_col);
      endcase
   endfunction

   function automatic void add(int n, fld_t f, int v, string name);
      vec_t t;
      t.n = n; t.f = f; t.v = v; t.name = name;
      vecs.push_back(t);
   endfunction

   // Expected layer writes queued when a run is launched
   task automatic push_run();
      for (int p = 0; p < 4096; p++) wr_q.push_back({3'b001, 12'(p)});
      if (POOL_ON != 0)
         for (int q = 0; q < 1024; q++) wr_q.push_back({3'b011, 12'(q)});
   endtask

   always @(negedge clk) begin : wr_monitor
      logic [14:0] e;
      if (cwr) begin
         if (wr_q.size() == 0) begin
            check("wr_sb_extra", 64'({csel, caddr_wr}), 64'(0));
         end else begin
            e = wr_q.pop_front();
            check("wr_sb", 64'({csel, caddr_wr}), 64'(e));
         end
      end
   end

   task automatic launch();
      push_run();
      @(negedge clk); ready = 1'b1;
      @(negedge clk); ready = 1'b0;
   endtask

   initial begin
      int sweep_err, busy_cnt, l1_cnt, mx_en_cnt, mx_clr_cnt;
      outv_t o;

      add(0,     F_BUSY,     1,    "busy_after_ready");
      add(0,     F_PAD,      1,    "p00_t0_pad");
      add(1,     F_PAD,      1,    "p00_t1_pad");
      add(1,     F_MCLR,     1,    "p00_mac_clr");
      add(2,     F_PAD,      1,    "p00_t2_pad");
      add(3,     F_PAD,      1,    "p00_t3_pad");
      add(4,     F_PAD,      0,    "p00_t4_nopad");
      add(4,     F_IADDR,    0,    "p00_t4_iaddr");
      add(5,     F_IADDR,    1,    "p00_t5_iaddr");
      add(6,     F_PAD,      1,    "p00_t6_pad");
      add(7,     F_IADDR,    64,   "p00_t7_iaddr");
      add(8,     F_IADDR,    65,   "p00_t8_iaddr");
      add(8,     F_TAP,      8,    "p00_t8_tap");
      add(9,     F_MEN,      1,    "p00_drain_mac_en");
      add(10,    F_MEN,      0,    "p00_wr_mac_en");
      add(10,    F_CWR,      1,    "p00_cwr");
      add(10,    F_CADDR_WR, 0,    "p00_caddr_wr");
      add(10,    F_CSEL,     1,    "p00_csel");
      add(703,   F_CADDR_WR, 63,   "p0_63_caddr_wr");
      add(708,   F_ROW,      1,    "wrap_row");
      add(708,   F_COL,      0,    "wrap_col");
      add(708,   F_IADDR,    64,   "wrap_t4_iaddr");
      add(714,   F_CADDR_WR, 64,   "wrap_caddr_wr");
      add(45047, F_PAD,      1,    "plast_t2_pad");
      add(45048, F_IADDR,    4094, "plast_t3_iaddr");
      add(45049, F_IADDR,    4095, "plast_t4_iaddr");
      add(45050, F_PAD,      1,    "plast_t5_pad");
      add(45051, F_PAD,      1,    "plast_t6_pad");
      add(45052, F_PAD,      1,    "plast_t7_pad");
      add(45053, F_PAD,      1,    "plast_t8_pad");
      add(45055, F_CADDR_WR, 4095, "plast_caddr_wr");
      add(45055, F_BUSY,     1,    "plast_busy");
      if (POOL_ON != 0) begin
         add(45056, F_CRD,      1,    "pool0_crd");
         add(45056, F_CADDR_RD, 0,    "pool0_rd0");
         add(45057, F_CADDR_RD, 1,    "pool0_rd1");
         add(45058, F_CADDR_RD, 64,   "pool0_rd2");
         add(45059, F_CADDR_RD, 65,   "pool0_rd3");
         add(45061, F_CADDR_WR, 0,    "pool0_caddr_wr");
         add(45061, F_CSEL,     3,    "pool0_csel");
         add(51194, F_CADDR_RD, 4030, "poolN_rd0");
         add(51195, F_CADDR_RD, 4031, "poolN_rd1");
         add(51196, F_CADDR_RD, 4094, "poolN_rd2");
         add(51197, F_CADDR_RD, 4095, "poolN_rd3");
         add(51199, F_CADDR_WR, 1023, "poolN_caddr_wr");
         add(51199, F_ROW,      31,   "poolN_row");
         add(51200, F_BUSY,     0,    "done_busy");
      end else begin
         add(45056, F_BUSY,     0,    "done_busy");
         add(45056, F_CSEL,     0,    "done_csel");
      end

      reset = 1'b1;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(sample()), 64'(0));
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_quiet", 64'(sample()), 64'(0));

      // Full run: every cycle against the model, with a ready pulse mid-run that must be ignored
      sweep_err = 0; busy_cnt = 0; l1_cnt = 0; mx_en_cnt = 0; mx_clr_cnt = 0;
      launch();
      for (int n = 0; n <= RUN_CYC + 1; n++) begin
         o = sample();
         obs[n] = o;
         if (o !== model(n)) begin
            sweep_err++;
            if (sweep_err <= 5)
               $display("sweep deviation at n=%0d: got 0x%0h, want 0x%0h", n, o, model(n));
         end
         if (o.busy) busy_cnt++;
         if (o.csel == 3'b011) l1_cnt++;
         if (o.max_en) mx_en_cnt++;
         if (o.max_clr) mx_clr_cnt++;
         if (n == 500) ready = 1'b1;
         if (n == 501) ready = 1'b0;
         if (n != RUN_CYC + 1) @(negedge clk);
      end
      check("sweep_deviations", 64'(sweep_err), 64'(0));
      check("busy_cycles", 64'(busy_cnt), 64'(RUN_CYC));
      check("csel_l1_cycles", 64'(l1_cnt), 64'(POOL_ON * 1024));
      check("max_en_cycles", 64'(mx_en_cnt), 64'(POOL_ON * 4096));
      check("max_clr_cycles", 64'(mx_clr_cnt), 64'(POOL_ON * 1024));
      check("wr_sb_drained", 64'(wr_q.size()), 64'(0));

      foreach (vecs[i])
         check(vecs[i].name, 64'(get(obs[vecs[i].n], vecs[i].f)), 64'(vecs[i].v));

      // Reset during pixel 100, then a fresh run must restart at (0,0)
      launch();
      for (int n = 0; n < 1104; n++) @(negedge clk);
      check("pix100_tap", 64'(tap), 64'(4));
      check("pix100_row", 64'({pos_row, pos_col}), 64'({6'd1, 6'd36}));
      reset = 1'b1;
      @(negedge clk);
      check("midrun_reset_zero", 64'(sample()), 64'(0));
      reset = 1'b0;
      wr_q.delete();
      @(negedge clk);
      check("post_reset_idle", 64'(sample()), 64'(0));

      launch();
      for (int n = 0; n <= 10; n++) begin
         check($sformatf("restart_n%0d", n), 64'(sample()), 64'(model(n)));
         if (n != 10) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      wr_q.delete();
      reset = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
